reg_access_ctrl: RTL and testbench
==================================

// Module: reg_access_ctrl
// PURPOSE
//  Instruction decode/sequencing controller on the command side of the 8x8 register file.
//  Accepts 32-bit instructions over a valid/ready handshake and decodes each one.
//  Drives the register-file address and WRITE controls, and the ALU op and mux selects.
//  Fixed 4-state sequence per instruction; throughput 1 instruction / 4 CLK cycles.
// PARAMETERS
//  INSTR_W   32  instruction width; fields OP[31:24] DEST[23:16] SRC1[15:8] SRC2/IMM[7:0]
//  DATA_W    8   datapath width (IMMEDIATE, OFFSET)
//  ADDR_W    3   register address width; DEST/SRC1/SRC2 use bits [ADDR_W-1:0], upper bits ignored
//  CNT_W     16  retired-instruction counter width (optional feature only)
// PORTS
//  CLK          in   1        clock; all state changes on posedge
//  RESET        in   1        reset, synchronous, active-high
//  INSTR        in   INSTR_W  instruction word
//  INSTR_VALID  in   1        INSTR valid
//  INSTR_READY  out  1        controller idle, accepts INSTR
//  ZERO         in   1        ALU zero flag (used by beq)
//  INADDRESS    out  ADDR_W   register-file write address
//  OUT1ADDRESS  out  ADDR_W   register-file read port 1 address
//  OUT2ADDRESS  out  ADDR_W   register-file read port 2 address
//  WRITE        out  1        register-file write enable, one-cycle pulse
//  ALUOP        out  3        000 FWD, 001 ADD, 010 AND, 011 OR
//  IMM_SEL      out  1        1: ALU operand2 = IMMEDIATE
//  NEG_SEL      out  1        1: ALU operand2 negated (2's complement)
//  IMMEDIATE    out  DATA_W   INSTR[7:0] of the held instruction
//  OFFSET       out  DATA_W   INSTR[23:16], signed jump/branch offset
//  PC_LOAD      out  1        one-cycle pulse: PC += OFFSET (taken j/beq)
//  ILLEGAL      out  1        one-cycle pulse: undefined opcode
// BEHAVIOUR
//  Opcodes: 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or, 06 j, 07 beq; 08-FF illegal.
//  States: IDLE -> DECODE -> EXECUTE -> WBACK -> IDLE. INSTR_READY = (state==IDLE).
//  IDLE: on INSTR_VALID & INSTR_READY at a posedge, capture INSTR into IR and go to DECODE.
//    Without VALID, stay in IDLE. IR holds its value until the next accept.
//  Address outputs are registered from IR fields at the accept edge, then held stable until the next accept.
//    OUT1ADDRESS=SRC1, OUT2ADDRESS=SRC2, INADDRESS=DEST.
//    This gives the register file >=2 full cycles of read settling before WBACK.
//  Select outputs (ALUOP/IMM_SEL/NEG_SEL) are valid from the DECODE cycle through WBACK.
//    loadi: FWD,IMM=1 | mov: FWD | add: ADD | sub: ADD,NEG=1 | and: AND | or: OR
//    beq: ADD,NEG=1 | j: FWD.
//  EXECUTE: sample ZERO into a branch flag (beq only).
//  WBACK:
//    WRITE=1 for exactly this cycle for opcodes 00-05.
//    PC_LOAD=1 for j always, and for beq if the sampled ZERO==1.
//    Illegal opcode: WRITE=0, PC_LOAD=0, ILLEGAL=1; selects forced to 0.
//  WRITE, PC_LOAD and ILLEGAL are never asserted outside WBACK and never in the same cycle as each other.
//  INSTR_VALID outside IDLE is ignored. No instruction is queued; the source must hold it until accepted.
//  RESET (any state, incl. mid-instruction): next posedge state=IDLE, IR=0, and all outputs 0.
//    Exception: INSTR_READY=1 after reset.
//    A WRITE/PC_LOAD pending in that cycle is suppressed.
//  Reset values: INSTR_READY 1; all other outputs 0.
// CONFIGURATION
//  RAC_PERF_COUNT_EN defined:
//    adds out port RETIRED [CNT_W-1:0].
//    Increments once per WBACK of a legal opcode; ILLEGAL does not count.
//    Wraps 2^CNT_W-1 -> 0; cleared by RESET.
//  RAC_PERF_COUNT_EN undefined: no port, no counter logic; behaviour otherwise identical.
// TESTING
//  1. RESET=1 for 2 cycles -> INSTR_READY=1, WRITE=0, PC_LOAD=0, all addresses 0.
//  2. Accept 0x00_02_00_2A (loadi r2,42):
//     INADDRESS=2, IMM_SEL=1, IMMEDIATE=0x2A.
//     WRITE=1 exactly 3 cycles after accept, INSTR_READY back to 1 the cycle after.
//  3. Accept 0x03_04_01_02 (sub r4,r1,r2):
//     OUT1ADDRESS=1, OUT2ADDRESS=2, ALUOP=001, NEG_SEL=1, one WRITE pulse to r4.
//  4. beq offset 0xFE with ZERO=1 at EXECUTE -> PC_LOAD pulse, OFFSET=0xFE, WRITE=0.
//     Repeat with ZERO=0 -> no PC_LOAD.
//  5. Accept opcode 0x1F -> ILLEGAL pulse in WBACK, WRITE=0.
//     INSTR_VALID held high during DECODE/EXECUTE -> no second accept until IDLE.
//  6. Assert RESET in EXECUTE of an add -> no WRITE pulse, IDLE next cycle.
//     With RAC_PERF_COUNT_EN: RETIRED=0 after reset.
//     Then 3 legal instructions -> RETIRED=3.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: command-side decode/sequencing controller for the 8x8
// register file. Each accepted instruction walks IDLE->DECODE->EXECUTE->WBACK,
// giving one instruction per four CLK cycles.
// Optional build macro RAC_PERF_COUNT_EN adds the RETIRED instruction counter.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a new instruction; accept captures IR and addresses
// DECODE  | addresses and selects stable, register file read settling
// EXECUTE | ZERO sampled; WBACK pulses registered for the next cycle
// WBACK   | exactly one of WRITE / PC_LOAD / ILLEGAL may be high
module reg_access_ctrl #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic               ZERO,
  output logic [ADDR_W-1:0]  INADDRESS,
  output logic [ADDR_W-1:0]  OUT1ADDRESS,
  output logic [ADDR_W-1:0]  OUT2ADDRESS,
  output logic               WRITE,
  output logic [2:0]         ALUOP,
  output logic               IMM_SEL,
  output logic               NEG_SEL,
  output logic [DATA_W-1:0]  IMMEDIATE,
  output logic [DATA_W-1:0]  OFFSET,
  output logic               PC_LOAD,
  output logic               ILLEGAL
`ifdef RAC_PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0]   RETIRED
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    WBACK   = 2'd3
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_t             state;
  logic [INSTR_W-1:0] ir;

  logic [7:0] in_op;
  logic [7:0] ir_op;
  logic [2:0] dec_aluop;
  logic       dec_imm_sel;
  logic       dec_neg_sel;
  logic       ir_writes;
  logic       ir_is_j;
  logic       ir_is_beq;
  logic       ir_legal;

  assign in_op = INSTR[31:24];
  assign ir_op = ir[31:24];

  // Fields not routed anywhere (upper address bits of SRC1, tail of a wider IR).
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[15:8+ADDR_W], INSTR[15:8+ADDR_W]};

  assign INSTR_READY = (state == IDLE);
  assign IMMEDIATE   = ir[DATA_W-1:0];
  assign OFFSET      = ir[16 +: DATA_W];

  // Select decode of the incoming word, latched at accept so selects are valid in DECODE.
  always_comb begin
    dec_aluop   = ALU_FWD;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    case (in_op)
      OP_LOADI: dec_imm_sel = 1'b1;
      OP_MOV:   dec_aluop   = ALU_FWD;
      OP_ADD:   dec_aluop   = ALU_ADD;
      OP_SUB:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; end
      OP_AND:   dec_aluop   = ALU_AND;
      OP_OR:    dec_aluop   = ALU_OR;
      OP_J:     dec_aluop   = ALU_FWD;
      OP_BEQ:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; end
      default:  dec_aluop   = ALU_FWD;
    endcase
  end

  // Class of the held instruction, used when arming the WBACK pulses.
  always_comb begin
    ir_writes = (ir_op <= OP_OR);
    ir_is_j   = (ir_op == OP_J);
    ir_is_beq = (ir_op == OP_BEQ);
    ir_legal  = (ir_op <= OP_BEQ);
  end

  // Sequencer: state, IR, registered addresses/selects and the WBACK pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      ir          <= '0;
      INADDRESS   <= '0;
      OUT1ADDRESS <= '0;
      OUT2ADDRESS <= '0;
      ALUOP       <= ALU_FWD;
      IMM_SEL     <= 1'b0;
      NEG_SEL     <= 1'b0;
      WRITE       <= 1'b0;
      PC_LOAD     <= 1'b0;
      ILLEGAL     <= 1'b0;
    end else begin
      WRITE   <= 1'b0;
      PC_LOAD <= 1'b0;
      ILLEGAL <= 1'b0;
      case (state)
        IDLE: begin
          if (INSTR_VALID) begin
            ir          <= INSTR;
            INADDRESS   <= INSTR[16 +: ADDR_W];
            OUT1ADDRESS <= INSTR[8 +: ADDR_W];
            OUT2ADDRESS <= INSTR[0 +: ADDR_W];
            ALUOP       <= dec_aluop;
            IMM_SEL     <= dec_imm_sel;
            NEG_SEL     <= dec_neg_sel;
            state       <= DECODE;
          end
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          // ZERO is sampled here; the PC_LOAD register doubles as the branch flag.
          WRITE   <= ir_writes;
          PC_LOAD <= ir_is_j | (ir_is_beq & ZERO);
          ILLEGAL <= ~ir_legal;
          state   <= WBACK;
        end
        WBACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAC_PERF_COUNT_EN
  // Retired-instruction counter, bumped as a legal instruction enters WBACK.
  always_ff @(posedge CLK) begin
    if (RESET)
      RETIRED <= '0;
    else if (state == EXECUTE && ir_legal)
      RETIRED <= RETIRED + CNT_W'(1);
  end
`else
  localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: table of instructions with hand-derived outputs,
// plus hand-written reset sequences.
module tb_reg_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTR = '0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic        ZERO = 1'b0;
  logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic        WRITE;
  logic [2:0]  ALUOP;
  logic        IMM_SEL, NEG_SEL;
  logic [7:0]  IMMEDIATE, OFFSET;
  logic        PC_LOAD, ILLEGAL;
`ifdef RAC_PERF_COUNT_EN
  logic [15:0] RETIRED;
  int          exp_retired = 0;
`endif

  int checks = 0;
  int failures = 0;

  reg_access_ctrl dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ZERO(ZERO), .INADDRESS(INADDRESS),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .WRITE(WRITE),
    .ALUOP(ALUOP), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE),
    .OFFSET(OFFSET), .PC_LOAD(PC_LOAD), .ILLEGAL(ILLEGAL)
`ifdef RAC_PERF_COUNT_EN
    , .RETIRED(RETIRED)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  in_a, o1_a, o2_a;
    logic [2:0]  aluop;
    logic        imm_sel, neg_sel;
    logic [7:0]  imm, off;
    logic        wr, pcl, ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Apply one instruction and check every cycle from DECODE back to IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    string t;
    n = 0;
    while (!INSTR_READY && n < 10) begin
      step();
      n++;
    end
    t = $sformatf("v%0d", idx);
    check({t, "_ready_wait"}, INSTR_READY, 1);
    INSTR = v.instr;
    ZERO = v.zero;
    INSTR_VALID = 1'b1;
    step();
    check({t, "_dec_ready"}, INSTR_READY, 0);
    check({t, "_inaddr"}, INADDRESS, v.in_a);
    check({t, "_out1addr"}, OUT1ADDRESS, v.o1_a);
    check({t, "_out2addr"}, OUT2ADDRESS, v.o2_a);
    check({t, "_aluop"}, ALUOP, v.aluop);
    check({t, "_imm_sel"}, IMM_SEL, v.imm_sel);
    check({t, "_neg_sel"}, NEG_SEL, v.neg_sel);
    check({t, "_immediate"}, IMMEDIATE, v.imm);
    check({t, "_offset"}, OFFSET, v.off);
    check({t, "_dec_pulses"}, {WRITE, PC_LOAD, ILLEGAL}, 3'b000);
    INSTR = 32'h0201_0203;
    step();
    check({t, "_exe_ready"}, INSTR_READY, 0);
    check({t, "_exe_pulses"}, {WRITE, PC_LOAD, ILLEGAL}, 3'b000);
    step();
    INSTR_VALID = 1'b0;
    check({t, "_wb_ready"}, INSTR_READY, 0);
    check({t, "_wb_pulses"}, {WRITE, PC_LOAD, ILLEGAL}, {v.wr, v.pcl, v.ill});
    check({t, "_wb_sel"}, {ALUOP, IMM_SEL, NEG_SEL}, {v.aluop, v.imm_sel, v.neg_sel});
    check({t, "_wb_inaddr"}, INADDRESS, v.in_a);
`ifdef RAC_PERF_COUNT_EN
    if (!v.ill) exp_retired++;
    check({t, "_retired"}, RETIRED, exp_retired);
`endif
    step();
    check({t, "_idle_ready"}, INSTR_READY, 1);
    check({t, "_idle_pulses"}, {WRITE, PC_LOAD, ILLEGAL}, 3'b000);
  endtask

  initial begin
    //          instr         z   in    o1    o2    alu     imm   neg   IMM    OFF    wr    pcl   ill
    vecs[0]  = '{32'h0002_002A, 0, 3'd2, 3'd0, 3'd2, 3'b000, 1'b1, 1'b0, 8'h2A, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h0304_0102, 0, 3'd4, 3'd1, 3'd2, 3'b001, 1'b0, 1'b1, 8'h02, 8'h04, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h07FE_0102, 1, 3'd6, 3'd1, 3'd2, 3'b001, 1'b0, 1'b1, 8'h02, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h07FE_0102, 0, 3'd6, 3'd1, 3'd2, 3'b001, 1'b0, 1'b1, 8'h02, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h1F12_3456, 1, 3'd2, 3'd4, 3'd6, 3'b000, 1'b0, 1'b0, 8'h56, 8'h12, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h0205_0607, 0, 3'd5, 3'd6, 3'd7, 3'b001, 1'b0, 1'b0, 8'h07, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h0401_0203, 0, 3'd1, 3'd2, 3'd3, 3'b010, 1'b0, 1'b0, 8'h03, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h0507_0605, 0, 3'd7, 3'd6, 3'd5, 3'b011, 1'b0, 1'b0, 8'h05, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h01FB_0D00, 0, 3'd3, 3'd5, 3'd0, 3'b000, 1'b0, 1'b0, 8'h00, 8'hFB, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h0610_0000, 0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h0803_0201, 1, 3'd3, 3'd2, 3'd1, 3'b000, 1'b0, 1'b0, 8'h01, 8'h03, 1'b0, 1'b0, 1'b1};

    RESET = 1'b1;
    step();
    step();
    check("rst_ready", INSTR_READY, 1);
    check("rst_pulses", {WRITE, PC_LOAD, ILLEGAL}, 3'b000);
    check("rst_addr", {INADDRESS, OUT1ADDRESS, OUT2ADDRESS}, 9'd0);
    check("rst_sel", {ALUOP, IMM_SEL, NEG_SEL}, 5'd0);
    check("rst_imm_off", {IMMEDIATE, OFFSET}, 16'd0);
`ifdef RAC_PERF_COUNT_EN
    check("rst_retired", RETIRED, 0);
`endif
    RESET = 1'b0;
    step();
    step();
    check("idle_no_valid", INSTR_READY, 1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset in EXECUTE of an add: the pending WRITE must never appear.
    INSTR = 32'h0205_0607;
    INSTR_VALID = 1'b1;
    step();
    INSTR_VALID = 1'b0;
    check("mrst_dec_ready", INSTR_READY, 0);
    step();
    RESET = 1'b1;
    step();
    check("mrst_ready", INSTR_READY, 1);
    check("mrst_pulses", {WRITE, PC_LOAD, ILLEGAL}, 3'b000);
    check("mrst_addr", {INADDRESS, OUT1ADDRESS, OUT2ADDRESS}, 9'd0);
    check("mrst_aluop", ALUOP, 0);
`ifdef RAC_PERF_COUNT_EN
    check("mrst_retired", RETIRED, 0);
    exp_retired = 0;
`endif
    RESET = 1'b0;
    step();
    check("mrst_late_write", WRITE, 0);
    check("mrst_idle", INSTR_READY, 1);

    for (int i = 0; i < 3; i++) run_vec(vecs[i], 20 + i);
`ifdef RAC_PERF_COUNT_EN
    check("retired_three", RETIRED, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
